ccg4_stage_ctrl: RTL and testbench

- Parametrised stage-4 control code generator for the pipelined RISC core.
- Registers the stage-3 control bundle, opcode and selected flag, and decodes the stage-4 controls: load SP, decrement SP, load output port, flag-evaluate.
- Resolves conditional squash of memory writes and SP adjustment.
- New over the previous generation: pipeline stall/flush handshake, one-hot output-port select, and a stack-depth tracker with sticky overflow/underflow faults.

---
 rtl/ccg4_stage_ctrl_if.sv | 54 +++++
 rtl/ccg4_stage_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ccg4_stage_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccg4_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// ccg4_stage_ctrl_if
// Purpose : Bundles the stage-3 -> stage-4 control handshake and the stage-4
//           control outputs of the RISC core pipeline.
// Signals : flush, stall, clr_fault        pipeline / fault handshake
//           valid_in, opcode_in, flag_in   stage-3 bundle qualifier and opcode
//           wr_in, xrn_in, xr0_in, ern_in, isp_in   stage-3 controls
//           valid_out, wr, lrn, lr0, ern, lsp, dsp  stage-4 controls
//           lop_vec                        one-hot output-port load
//           stack_depth, stack_ovf, stack_udf   stack tracker state/faults
// Modports: master drives the stage inputs, slave is the stage-4 controller.
// ---------------------------------------------------------------------------
interface ccg4_stage_ctrl_if #(
   parameter int NUM_OUT_PORTS = 8,
   parameter int DEPTH_W       = 5
);
   logic                     flush;
   logic                     stall;
   logic                     valid_in;
   logic [7:0]               opcode_in;
   logic                     flag_in;
   logic                     wr_in;
   logic                     xrn_in;
   logic                     xr0_in;
   logic                     ern_in;
   logic                     isp_in;
   logic                     clr_fault;

   logic                     valid_out;
   logic                     wr;
   logic                     lrn;
   logic                     lr0;
   logic                     ern;
   logic                     lsp;
   logic                     dsp;
   logic [NUM_OUT_PORTS-1:0] lop_vec;
   logic [DEPTH_W-1:0]       stack_depth;
   logic                     stack_ovf;
   logic                     stack_udf;

   modport master (
      output flush, stall, valid_in, opcode_in, flag_in,
             wr_in, xrn_in, xr0_in, ern_in, isp_in, clr_fault,
      input  valid_out, wr, lrn, lr0, ern, lsp, dsp,
             lop_vec, stack_depth, stack_ovf, stack_udf
   );

   modport slave (
      input  flush, stall, valid_in, opcode_in, flag_in,
             wr_in, xrn_in, xr0_in, ern_in, isp_in, clr_fault,
      output valid_out, wr, lrn, lr0, ern, lsp, dsp,
             lop_vec, stack_depth, stack_ovf, stack_udf
   );
endinterface

// File: rtl/ccg4_stage_ctrl.sv
// ---------------------------------------------------------------------------
// ccg4_stage_ctrl
// Purpose : Stage-4 control code generator. Registers the stage-3 control
//           bundle, decodes the stage-4 controls (LSP, DSP, LOP, EFL),
//           squashes memory writes / SP adjustment on a failed condition,
//           drives a one-hot output-port load and tracks the stack depth
//           with sticky overflow / underflow faults.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - ccg4_stage_ctrl_if.slave (handshake, controls, tracker)
// ---------------------------------------------------------------------------
module ccg4_stage_ctrl #(
   parameter int NUM_OUT_PORTS = 8,
   parameter int STACK_DEPTH   = 16,
   parameter int DEPTH_W       = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   ccg4_stage_ctrl_if.slave      bus
);

   // {LSP, DSP, LOP, EFL} for a registered opcode
   function automatic logic [3:0] decode_op(input logic [7:0] op);
      logic [3:0] d;
      d = 4'b0000;
      casez (op)
         8'h05, 8'h06:   d = 4'b0100;  // CUD, CUA
         8'b0000_1???:   d = 4'b0001;  // JCD
         8'b0010_1???:   d = 4'b0001;  // JCA
         8'h10:          d = 4'b1000;  // LSP
         8'b0011_????:   d = 4'b0101;  // CCD, CCA
         8'b0100_1???:   d = 4'b0001;  // RTC
         8'b0110_1???:   d = 4'b0100;  // PSH
         8'b1111_1???:   d = 4'b0010;  // OUT
         default:        d = 4'b0000;
      endcase
      return d;
   endfunction

   logic                     r_vld_p1;
   logic [7:0]               r_opcode_p1;
   logic                     r_flag_p1;
   logic                     r_wr_p1;
   logic                     r_xrn_p1;
   logic                     r_xr0_p1;
   logic                     r_ern_p1;
   logic                     r_isp_p1;

   logic [DEPTH_W-1:0]       r_depth;
   logic                     r_ovf;
   logic                     r_udf;

   logic [3:0]               w_dec_bits;
   logic                     w_lsp;
   logic                     w_dsp_op;
   logic                     w_lop;
   logic                     w_efl;
   logic                     w_cond_fail;
   logic                     w_dsp_raw;
   logic                     w_wr_raw;
   logic                     w_inc;
   logic                     w_dec;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_upd;
   logic                     w_ovf_now;
   logic                     w_ovf_set;
   logic                     w_udf_set;
   logic [NUM_OUT_PORTS-1:0] w_lop_vec;

   // ---- stage 3 -> stage 4 register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p1    <= 1'b0;
         r_opcode_p1 <= '0;
         r_flag_p1   <= 1'b0;
         r_wr_p1     <= 1'b0;
         r_xrn_p1    <= 1'b0;
         r_xr0_p1    <= 1'b0;
         r_ern_p1    <= 1'b0;
         r_isp_p1    <= 1'b0;
      end else if (bus.flush) begin
         r_vld_p1    <= 1'b0;
         r_opcode_p1 <= '0;
         r_flag_p1   <= 1'b0;
         r_wr_p1     <= 1'b0;
         r_xrn_p1    <= 1'b0;
         r_xr0_p1    <= 1'b0;
         r_ern_p1    <= 1'b0;
         r_isp_p1    <= 1'b0;
      end else if (!bus.stall) begin
         r_vld_p1    <= bus.valid_in;
         r_opcode_p1 <= bus.opcode_in;
         r_flag_p1   <= bus.flag_in;
         r_wr_p1     <= bus.valid_in & bus.wr_in;
         r_xrn_p1    <= bus.valid_in & bus.xrn_in;
         r_xr0_p1    <= bus.valid_in & bus.xr0_in;
         r_ern_p1    <= bus.valid_in & bus.ern_in;
         r_isp_p1    <= bus.valid_in & bus.isp_in;
      end
   end

   // ---- stage 4 decode, squash and port select ----
   always_comb begin
      // Gate the decode with valid so a stale opcode in a bubble decodes to 0
      w_dec_bits  = r_vld_p1 ? decode_op(r_opcode_p1) : 4'b0000;
      w_lsp       = w_dec_bits[3];
      w_dsp_op    = w_dec_bits[2];
      w_lop       = w_dec_bits[1];
      w_efl       = w_dec_bits[0];

      w_cond_fail = w_efl & ~r_flag_p1;
      // A failed conditional return undoes the stage-3 SP pre-increment
      w_dsp_raw   = w_cond_fail ? r_isp_p1 : w_dsp_op;
      w_wr_raw    = r_wr_p1 & ~w_cond_fail;

      // Net SP movement: dsp_raw - isp
      w_inc       = w_dsp_raw & ~r_isp_p1;
      w_dec       = ~w_dsp_raw & r_isp_p1;
      w_full      = (r_depth == DEPTH_W'(STACK_DEPTH));
      w_empty     = (r_depth == '0);

      // Overflow suppression is held stable across a stall; the fault itself
      // is only recorded on the cycle the instruction leaves the stage
      w_ovf_now   = w_inc & w_full & ~w_lsp;
      w_upd       = r_vld_p1 & ~bus.stall & ~bus.flush;
      w_ovf_set   = w_upd & w_ovf_now;
      w_udf_set   = w_upd & w_dec & w_empty & ~w_lsp;

      // Ports at or beyond NUM_OUT_PORTS match no bit and are ignored
      w_lop_vec   = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         if (r_opcode_p1[2:0] == 3'(i)) w_lop_vec[i] = w_lop;
      end
   end

   // ---- stack tracker ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_upd) begin
            if (w_lsp)
               r_depth <= '0;
            else if (w_inc && !w_full)
               r_depth <= r_depth + 1'b1;
            else if (w_dec && !w_empty)
               r_depth <= r_depth - 1'b1;
         end
         // A fault raised in the same cycle as clr_fault stays set
         r_ovf <= w_ovf_set | (r_ovf & ~bus.clr_fault);
         r_udf <= w_udf_set | (r_udf & ~bus.clr_fault);
      end
   end

   assign bus.valid_out   = r_vld_p1;
   assign bus.wr          = w_wr_raw & ~w_ovf_now;
   assign bus.dsp         = w_dsp_raw & ~w_ovf_now;
   assign bus.lrn         = r_xrn_p1;
   assign bus.lr0         = r_xr0_p1;
   assign bus.ern         = r_ern_p1;
   assign bus.lsp         = w_lsp;
   assign bus.lop_vec     = w_lop_vec;
   assign bus.stack_depth = r_depth;
   assign bus.stack_ovf   = r_ovf;
   assign bus.stack_udf   = r_udf;

endmodule

// File: tb/tb_ccg4_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ccg4_stage_ctrl
// Purpose : Directed self-checking bench for ccg4_stage_ctrl with
//           NUM_OUT_PORTS=8, STACK_DEPTH=16, DEPTH_W=5.
// ---------------------------------------------------------------------------
module tb_ccg4_stage_ctrl;

   localparam int NOP = 8;
   localparam int SD  = 16;
   localparam int DW  = 5;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ccg4_stage_ctrl_if #(.NUM_OUT_PORTS(NOP), .DEPTH_W(DW)) bus ();

   ccg4_stage_ctrl #(
      .NUM_OUT_PORTS(NOP),
      .STACK_DEPTH  (SD),
      .DEPTH_W      (DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.valid_in  = 1'b0;
      bus.opcode_in = 8'h00;
      bus.flag_in   = 1'b0;
      bus.wr_in     = 1'b0;
      bus.xrn_in    = 1'b0;
      bus.xr0_in    = 1'b0;
      bus.ern_in    = 1'b0;
      bus.isp_in    = 1'b0;
   endtask

   task automatic issue(input logic [7:0] op, input logic flg, input logic w, input logic isp);
      bus.valid_in  = 1'b1;
      bus.opcode_in = op;
      bus.flag_in   = flg;
      bus.wr_in     = w;
      bus.xrn_in    = 1'b0;
      bus.xr0_in    = 1'b0;
      bus.ern_in    = 1'b0;
      bus.isp_in    = isp;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      bus.clr_fault = 1'b0;
      idle();

      // Reset state
      tick();
      tick();
      chk("rst_valid", 32'(bus.valid_out), 32'd0);
      chk("rst_depth", 32'(bus.stack_depth), 32'd0);
      chk("rst_ovf", 32'(bus.stack_ovf), 32'd0);
      chk("rst_udf", 32'(bus.stack_udf), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_dsp", 32'(bus.dsp), 32'd0);

      // CUD: dsp next cycle, depth 0 -> 1 on the following edge
      issue(8'h05, 1'b0, 1'b0, 1'b0);
      tick();
      chk("cud_valid", 32'(bus.valid_out), 32'd1);
      chk("cud_dsp", 32'(bus.dsp), 32'd1);
      chk("cud_wr", 32'(bus.wr), 32'd0);
      chk("cud_depth_before", 32'(bus.stack_depth), 32'd0);
      idle();
      tick();
      chk("cud_depth_after", 32'(bus.stack_depth), 32'd1);
      chk("bubble_valid", 32'(bus.valid_out), 32'd0);

      // Pass-through controls
      issue(8'h00, 1'b0, 1'b0, 1'b0);
      bus.xrn_in = 1'b1;
      bus.ern_in = 1'b1;
      tick();
      chk("pass_lrn", 32'(bus.lrn), 32'd1);
      chk("pass_lr0", 32'(bus.lr0), 32'd0);
      chk("pass_ern", 32'(bus.ern), 32'd1);

      // CCD with flag false: write and SP adjust squashed
      issue(8'h31, 1'b0, 1'b1, 1'b0);
      tick();
      chk("ccd_f_wr", 32'(bus.wr), 32'd0);
      chk("ccd_f_dsp", 32'(bus.dsp), 32'd0);
      idle();
      tick();
      chk("ccd_f_depth", 32'(bus.stack_depth), 32'd1);

      // CCD with flag true
      issue(8'h31, 1'b1, 1'b1, 1'b0);
      tick();
      chk("ccd_t_wr", 32'(bus.wr), 32'd1);
      chk("ccd_t_dsp", 32'(bus.dsp), 32'd1);
      idle();
      tick();
      chk("ccd_t_depth", 32'(bus.stack_depth), 32'd2);

      // RTC with flag false: pre-increment undone, net 0
      issue(8'h4A, 1'b0, 1'b0, 1'b1);
      tick();
      chk("rtc_f_dsp", 32'(bus.dsp), 32'd1);
      idle();
      tick();
      chk("rtc_f_depth", 32'(bus.stack_depth), 32'd2);

      // RTC with flag true: net -1
      issue(8'h4A, 1'b1, 1'b0, 1'b1);
      tick();
      chk("rtc_t_dsp", 32'(bus.dsp), 32'd0);
      idle();
      tick();
      chk("rtc_t_depth", 32'(bus.stack_depth), 32'd1);

      // LSP clears depth
      issue(8'h10, 1'b0, 1'b0, 1'b0);
      tick();
      chk("lsp1_lsp", 32'(bus.lsp), 32'd1);
      idle();
      tick();
      chk("lsp1_depth", 32'(bus.stack_depth), 32'd0);

      // Overflow: 16 back-to-back pushes, then a 17th
      issue(8'h68, 1'b0, 1'b1, 1'b0);
      tick();
      chk("psh_wr", 32'(bus.wr), 32'd1);
      chk("psh_dsp", 32'(bus.dsp), 32'd1);
      for (int i = 1; i < 16; i++) tick();
      idle();
      tick();
      chk("psh16_depth", 32'(bus.stack_depth), 32'd16);
      chk("psh16_ovf", 32'(bus.stack_ovf), 32'd0);
      issue(8'h68, 1'b0, 1'b1, 1'b0);
      tick();
      chk("ovf_dsp", 32'(bus.dsp), 32'd0);
      chk("ovf_wr", 32'(bus.wr), 32'd0);
      idle();
      tick();
      chk("ovf_flag", 32'(bus.stack_ovf), 32'd1);
      chk("ovf_depth", 32'(bus.stack_depth), 32'd16);
      tick();
      chk("ovf_sticky", 32'(bus.stack_ovf), 32'd1);
      bus.clr_fault = 1'b1;
      tick();
      bus.clr_fault = 1'b0;
      chk("ovf_clr", 32'(bus.stack_ovf), 32'd0);

      // Back to depth 0
      issue(8'h10, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      chk("lsp2_depth", 32'(bus.stack_depth), 32'd0);

      // Underflow: isp at depth 0 with no decoded DSP
      issue(8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      chk("udf_dsp", 32'(bus.dsp), 32'd0);
      idle();
      tick();
      chk("udf_flag", 32'(bus.stack_udf), 32'd1);
      chk("udf_depth", 32'(bus.stack_depth), 32'd0);
      // clr_fault acts while stalled
      bus.stall = 1'b1;
      bus.clr_fault = 1'b1;
      tick();
      bus.stall = 1'b0;
      bus.clr_fault = 1'b0;
      chk("udf_clr_stall", 32'(bus.stack_udf), 32'd0);

      // LSP at depth 5
      issue(8'h68, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      idle();
      tick();
      chk("psh5_depth", 32'(bus.stack_depth), 32'd5);
      issue(8'h10, 1'b0, 1'b0, 1'b0);
      tick();
      chk("lsp3_lsp", 32'(bus.lsp), 32'd1);
      idle();
      tick();
      chk("lsp3_depth", 32'(bus.stack_depth), 32'd0);

      // Stall with a live push: held, counted exactly once
      issue(8'h68, 1'b0, 1'b0, 1'b0);
      tick();
      bus.stall = 1'b1;
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_dsp", 32'(bus.dsp), 32'd1);
         chk("stall_depth", 32'(bus.stack_depth), 32'd0);
      end
      bus.stall = 1'b0;
      tick();
      chk("stall_rel_depth", 32'(bus.stack_depth), 32'd1);
      chk("stall_rel_valid", 32'(bus.valid_out), 32'd0);

      // OUT 0xFB, stall, then flush during stall
      issue(8'hFB, 1'b0, 1'b0, 1'b0);
      tick();
      chk("out_lop", 32'(bus.lop_vec), 32'h08);
      bus.stall = 1'b1;
      idle();
      tick();
      chk("out_stall_lop", 32'(bus.lop_vec), 32'h08);
      chk("out_stall_valid", 32'(bus.valid_out), 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      chk("flush_valid", 32'(bus.valid_out), 32'd0);
      chk("flush_lop", 32'(bus.lop_vec), 32'h00);
      chk("flush_depth", 32'(bus.stack_depth), 32'd1);

      // Reset mid-stream: immediate clear
      issue(8'h68, 1'b0, 1'b1, 1'b0);
      tick();
      chk("mid_dsp", 32'(bus.dsp), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.valid_out), 32'd0);
      chk("mid_rst_dsp", 32'(bus.dsp), 32'd0);
      chk("mid_rst_depth", 32'(bus.stack_depth), 32'd0);
      idle();
      tick();
      rst = 1'b0;
      tick();
      chk("after_rst_depth", 32'(bus.stack_depth), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
